legv8_fetch_buffer: RTL and testbench
=====================================

# legv8_fetch_buffer

Instruction-fetch front end for the pipelined LEGv8 core. It owns the fetch PC, drives the combinational instruction memory and captures the returned word. Fetched {PC, instruction} pairs go into a small FIFO that feeds the decode stage through a valid/ready handshake. Decode-side stalls are absorbed by the FIFO, and branch redirects from later stages flush it and restart fetch at the target.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 64'h0: fetch address after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-low.
- imem_addr  output  64  fetch address to instruction memory; always equals fetch_pc.
- imem_data  input  32  instruction word at imem_addr; valid combinationally in the same cycle.
- redirect_valid  input  1  branch/exception redirect request.
- redirect_pc  input  64  redirect target.
- id_ready  input  1  decode accepts the head entry this cycle.
- id_valid  output  1  head entry present.
- id_instr  output  32  head instruction.
- id_pc  output  64  PC of head instruction.
- count  output  log2(DEPTH)+1  number of occupied entries.

## Operation
- State:
  - fetch_pc (64 bits).
  - FIFO storage of DEPTH × (64+32) bits.
  - Read and write pointers, each log2(DEPTH) bits and wrapping modulo DEPTH.
  - count.
- id_valid = (count != 0).
- id_instr and id_pc show the head entry when id_valid=1, and read as 0 when the FIFO is empty.
- pop = id_valid & id_ready.
- push = !redirect_valid & ((count < DEPTH) | pop). A full FIFO accepts a new fetch in the same cycle it pops.
- On push:
  - Write {fetch_pc, imem_data} at the write pointer.
  - fetch_pc <= fetch_pc + 4, using 64-bit modulo arithmetic, so 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- No push → fetch_pc holds, and imem_addr stays stable.
- count' = count + push − pop. It never exceeds DEPTH and never goes negative.
- Redirect (redirect_valid=1) overrides all other actions:
  - Both pointers and count go to 0, and all entries are discarded.
  - A pop that would have happened in the same cycle is suppressed. Decode must treat the head as killed by its own redirect.
  - fetch_pc <= {redirect_pc[63:2], 2'b00}; the low two bits are forced to zero.
  - No push occurs in the redirect cycle.
- Back-to-back redirects: each one reloads fetch_pc, and the last one wins.
- No internal states beyond the FIFO and fetch_pc; the block behaves as the FETCH/STALL/FLUSH modes implied by count and redirect_valid.

## Timing
- Reset (reset=0, asynchronous assert):
  - fetch_pc=RESET_PC, count=0.
  - id_valid=0, id_instr=0, id_pc=0, imem_addr=RESET_PC.
- Deassertion is synchronized by the surrounding design. The block must not push on the edge where reset is low.
- Fill latency: the instruction at address A is fetched on edge k and appears at the head (id_valid=1) immediately after edge k, provided the FIFO was empty.
- Throughput: 1 instruction per cycle with id_ready=1 continuously. Entries then reside exactly one cycle.
- Redirect penalty:
  - Redirect sampled on edge N → after N, id_valid=0.
  - Target instruction pushed on edge N+1 → visible after N+1.
  - Net: one bubble cycle.
- id_* outputs are register/FIFO-read driven: no combinational path from id_ready or redirect_valid to id_valid, id_instr or id_pc.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Any in-flight entries are lost.

## Test plan
- Reset and stream: RESET_PC=0, imem returns {PC[31:2],2'b00} as data, id_ready=1 → after edges 1,2,3, id_pc = 0,4,8 with matching id_instr; count stays 1; no gaps.
- Backpressure: id_ready=0 for 6 cycles from reset → count rises 1..4 then holds at 4. imem_addr freezes at 0x10. Releasing id_ready gives id_pc 0,4,8,0xC,0x10 with no loss or duplication.
- Full + simultaneous pop: count=4 and id_ready=1 for one cycle → count stays 4, head advances by one entry, fetch_pc advances by 4.
- Redirect mid-stream: count=3, redirect_valid=1 with redirect_pc=0x1003 and id_ready=1:
  - next cycle: id_valid=0, count=0, imem_addr=0x1000;
  - following cycle: id_pc=0x1000.
- Address wrap: redirect to 0xFFFF_FFFF_FFFF_FFFC with id_ready=1 → id_pc sequence 0x…FFFC, 0x0, 0x4.
- Reset mid-operation: count=3, then assert reset between clock edges → id_valid, count and id_pc are 0 and imem_addr=RESET_PC before the next edge. Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/legv8_fetch_buffer.sv
// LEGv8 instruction-fetch front end.
// Owns the fetch PC, captures the combinational imem word each cycle and
// queues {pc, instr} pairs in a small FIFO feeding decode via valid/ready.
// A redirect flushes the queue and restarts fetch at the word-aligned target.
module legv8_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [63:0]                imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       redirect_valid,
  input  logic [63:0]                redirect_pc,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [63:0]                id_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [63:0]   fetch_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          pop;
  logic          push;
  logic [CW-1:0] cnt_next;

  assign imem_addr = fetch_pc;
  assign count     = cnt;
  assign id_valid  = (cnt != '0);

  // Head entry is shown only when occupied; empty FIFO reads as zero.
  always_comb begin
    id_instr = '0;
    id_pc    = '0;
    if (id_valid) begin
      id_instr = instr_mem[rd_ptr];
      id_pc    = pc_mem[rd_ptr];
    end
  end

  // Handshake decode: a full FIFO may still push when it pops in the same cycle.
  always_comb begin
    pop      = id_valid & id_ready;
    push     = !redirect_valid & ((cnt < DEPTH_C) | pop);
    cnt_next = cnt + CW'(push) - CW'(pop);
  end

  // Control state: fetch PC, pointers and occupancy; redirect overrides all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[63:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 64'd4;
        wr_ptr   <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt_next;
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_legv8_fetch_buffer.sv
// Directed bench for legv8_fetch_buffer: stream, backpressure, full+pop,
// redirect, back-to-back redirect, address wrap and mid-operation reset.
module tb_legv8_fetch_buffer;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [2:0]  count;

  int unsigned checks;
  int unsigned failures;

  legv8_fetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .count          (count)
  );

  // Instruction memory model: the word at an address is the address itself.
  assign imem_data = imem_addr[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp_pc;
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;

    // Reset state before any edge.
    #3;
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_pc", id_pc, 64'd0);
    check("rst_instr", 64'(id_instr), 64'd0);
    check("rst_imem_addr", imem_addr, 64'd0);

    // No push on an edge while reset is held low.
    tick();
    check("rst_edge_count", 64'(count), 64'd0);
    check("rst_edge_addr", imem_addr, 64'd0);
    reset = 1'b1;

    // Streaming with id_ready=1: one instruction per cycle, count stays 1.
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = 64'(i * 4);
      check("stream_pc", id_pc, exp_pc);
      check("stream_instr", 64'(id_instr), exp_pc);
      check("stream_count", 64'(count), 64'd1);
    end

    // Redirect back to 0 to start backpressure from an empty FIFO.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    tick();
    check("flush0_valid", 64'(id_valid), 64'd0);
    check("flush0_addr", imem_addr, 64'd0);
    redirect_valid = 1'b0;
    id_ready       = 1'b0;

    // Backpressure: count 1..4 then holds; imem_addr freezes at 0x10.
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("bp_count", 64'(count), (i < 4) ? 64'(i) : 64'd4);
      check("bp_addr", imem_addr, (i < 4) ? 64'(i * 4) : 64'h10);
      check("bp_head", id_pc, 64'd0);
    end

    // Full + simultaneous pop: count stays 4, head and fetch_pc advance.
    id_ready = 1'b1;
    tick();
    check("fullpop_count", 64'(count), 64'd4);
    check("fullpop_head", id_pc, 64'h4);
    check("fullpop_addr", imem_addr, 64'h14);

    // Drain order continues without loss or duplication.
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = 64'(8 + i * 4);
      check("drain_pc", id_pc, exp_pc);
      check("drain_instr", 64'(id_instr), exp_pc);
      check("drain_count", 64'(count), 64'd4);
    end

    // Build count=3 from an empty FIFO.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    tick(); tick(); tick();
    check("pre_redir_count", 64'(count), 64'd3);

    // Redirect mid-stream with id_ready=1: pop suppressed, target aligned.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    id_ready       = 1'b1;
    tick();
    check("redir_valid", 64'(id_valid), 64'd0);
    check("redir_count", 64'(count), 64'd0);
    check("redir_addr", imem_addr, 64'h1000);
    check("redir_pc_zero", id_pc, 64'd0);
    redirect_valid = 1'b0;
    tick();
    check("redir_tgt_pc", id_pc, 64'h1000);
    check("redir_tgt_instr", 64'(id_instr), 64'h1000);
    check("redir_tgt_count", 64'(count), 64'd1);
    tick();
    check("redir_next_pc", id_pc, 64'h1004);

    // Back-to-back redirects: last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    tick();
    redirect_pc    = 64'h3007;
    tick();
    check("b2b_addr", imem_addr, 64'h3004);
    check("b2b_valid", 64'(id_valid), 64'd0);
    redirect_valid = 1'b0;
    tick();
    check("b2b_pc", id_pc, 64'h3004);

    // Address wrap at the top of the 64-bit space.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("wrap_pc0", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr0", 64'(id_instr), 64'hFFFF_FFFC);
    tick();
    check("wrap_pc1", id_pc, 64'h0);
    tick();
    check("wrap_pc2", id_pc, 64'h4);

    // Reset mid-operation with count=3, asserted between edges.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    tick(); tick(); tick();
    check("midrst_pre_count", 64'(count), 64'd3);
    check("midrst_pre_addr", imem_addr, 64'hC);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_valid", 64'(id_valid), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_pc", id_pc, 64'd0);
    check("midrst_addr", imem_addr, 64'd0);
    #1;
    reset    = 1'b1;
    id_ready = 1'b1;
    tick();
    check("restart_pc0", id_pc, 64'd0);
    check("restart_count", 64'(count), 64'd1);
    tick();
    check("restart_pc1", id_pc, 64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
